// File: rtl/seg7_scan_driver_if.sv
// Display-register bus between the pipeline core and the seven-segment driver.
// Ports: display/hex_mode/result from the core; busy/AN/BCD back from the driver.
// The driver sits on the slave modport and the core side uses master.
interface seg7_scan_driver_if;
  logic        display;
  logic        hex_mode;
  logic [15:0] result;
  logic        busy;
  logic [3:0]  AN;
  logic [7:0]  BCD;

  modport master (
    output display, hex_mode, result,
    input  busy, AN, BCD
  );

  modport slave (
    input  display, hex_mode, result,
    output busy, AN, BCD
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Converts a 16-bit result to decimal (double-dabble) or hex and scans four
// common-anode digits. Latency: busy cycles 1..17 after the capture edge, digits valid cycle 18,
// pins from cycle 19. Backpressure: none; input changes during a conversion wait for the next IDLE.
// Ports: clk, reset (async active-low), bus.slave {display, hex_mode, result -> busy, AN, BCD}.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);
  localparam int unsigned   CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          state;
  logic [35:0]     sreg;        // {5 BCD nibbles, 16-bit binary}
  logic [3:0]      bit_cnt;
  logic [15:0]     cap_val;
  logic            cap_hex;
  logic [3:0][3:0] dig;
  logic [3:0]      blank;
  logic            ovf;
  logic            busy_q;

  logic [CW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic [1:0]      idx_nxt;
  logic [7:0]      seg_nxt;
  logic [3:0]      an_q;
  logic [7:0]      bcd_q;

  logic [3:0][3:0] lat_dig;
  logic [3:0]      lat_blank;
  logic            lat_ovf;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [35:0] dd_step(input logic [35:0] s);
    logic [35:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (r[16+4*i +: 4] >= 4'd5) r[16+4*i +: 4] = r[16+4*i +: 4] + 4'd3;
    end
    return {r[34:0], 1'b0};
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // Digit contents as they will be written in LATCH.
  always_comb begin
    lat_ovf   = 1'b0;
    lat_blank = 4'b0000;
    if (cap_hex) begin
      lat_dig = cap_val;
    end else begin
      lat_dig = sreg[31:16];
      lat_ovf = (sreg[35:32] != 4'd0);
      // Overflow shows the low four digits in full, so blanking is off then.
      if (BLANK_LZ && !lat_ovf) begin
        lat_blank[3] = (sreg[31:28] == 4'd0);
        lat_blank[2] = lat_blank[3] && (sreg[27:24] == 4'd0);
        lat_blank[1] = lat_blank[2] && (sreg[23:20] == 4'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      cap_val <= '0;
      cap_hex <= 1'b0;
      dig     <= '0;
      blank   <= '0;
      ovf     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.result != cap_val || bus.hex_mode != cap_hex) begin
            cap_val <= bus.result;
            cap_hex <= bus.hex_mode;
            sreg    <= {20'd0, bus.result};
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Hex mode also runs all 16 steps so latency does not depend on mode.
          sreg    <= dd_step(sreg);
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= LATCH;
        end
        LATCH: begin
          dig    <= lat_dig;
          blank  <= lat_blank;
          ovf    <= lat_ovf;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are registered from the post-edge index so anode and segments
  // always switch together.
  always_comb begin
    idx_nxt = idx;
    if (scan_cnt == CNT_MAX) idx_nxt = idx + 2'd1;
    seg_nxt = glyph(dig[idx_nxt]);
    if (ovf && idx_nxt == 2'd3) seg_nxt[7] = 1'b0;
    if (blank[idx_nxt]) seg_nxt = 8'hFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      an_q     <= 4'b1111;
      bcd_q    <= 8'hFF;
    end else begin
      scan_cnt <= (scan_cnt == CNT_MAX) ? '0 : scan_cnt + CW'(1);
      idx      <= idx_nxt;
      an_q     <= bus.display ? ~(4'b0001 << idx_nxt) : 4'b1111;
      bcd_q    <= bus.display ? seg_nxt : 8'hFF;
    end
  end

  assign bus.busy = busy_q;
  assign bus.AN   = an_q;
  assign bus.BCD  = bcd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (blanking on/off) with SCAN_DIV=4
// share the same stimulus; outputs are sampled on the falling clock edge.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus();
  seg7_scan_driver_if bus_nb();

  assign bus_nb.display  = bus.display;
  assign bus_nb.hex_mode = bus.hex_mode;
  assign bus_nb.result   = bus.result;

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_nb.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n;
    n = 0;
    while (bus.busy !== v && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 16'(bus.busy), 16'(v));
  endtask

  task automatic check_off(input string tag);
    check({tag, " an"}, 16'(bus.AN), 16'hF);
    check({tag, " bcd"}, 16'(bus.BCD), 16'hFF);
    check({tag, " busy"}, 16'(bus.busy), 16'h0);
    check({tag, " nb_an"}, 16'(bus_nb.AN), 16'hF);
  endtask

  // Align to the start of a frame, then check every digit, its glyph and its dwell.
  task automatic frame(input string tag,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3,
                       input logic [7:0] n0, input logic [7:0] n1,
                       input logic [7:0] n2, input logic [7:0] n3);
    logic [7:0] e [4];
    logic [7:0] nb [4];
    logic [3:0] exp_an;
    logic [3:0] cur;
    int w;
    int hold;
    e  = '{e0, e1, e2, e3};
    nb = '{n0, n1, n2, n3};
    w = 0;
    while (bus.AN !== 4'b0111 && w < 40) begin tick(1); w++; end
    w = 0;
    while (bus.AN === 4'b0111 && w < 10) begin tick(1); w++; end
    for (int k = 0; k < 4; k++) begin
      exp_an = ~(4'b0001 << k);
      check($sformatf("%s an%0d", tag, k), 16'(bus.AN), 16'(exp_an));
      check($sformatf("%s bcd%0d", tag, k), 16'(bus.BCD), 16'(e[k]));
      check($sformatf("%s nb_bcd%0d", tag, k), 16'(bus_nb.BCD), 16'(nb[k]));
      cur  = bus.AN;
      hold = 0;
      do begin
        hold++;
        tick(1);
      end while (bus.AN === cur && hold < 10);
      check($sformatf("%s hold%0d", tag, k), 16'(hold), 16'd4);
    end
  endtask

  initial begin
    bus.display  = 1'b1;
    bus.hex_mode = 1'b0;
    bus.result   = 16'd0;

    // Reset held: outputs stay at reset values while result toggles.
    tick(1);
    for (int i = 0; i < 3; i++) begin
      bus.result = 16'(i * 1111 + 5);
      tick(1);
      check_off($sformatf("rst%0d", i));
    end

    // Release with a nonzero value: conversion starts on the first edge.
    bus.result = 16'd1234;
    reset = 1'b1;
    tick(1);
    check("post_rst busy", 16'(bus.busy), 16'h1);
    begin
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin n++; tick(1); end
      check("busy_len", 16'(n), 16'd17);
    end
    frame("d1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Leading-zero blanking on the main instance, full zeros on the other.
    bus.result = 16'd7;
    wait_busy(1'b1, "lz busy_up");
    wait_busy(1'b0, "lz busy_dn");
    frame("d7", 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0, 8'hC0);

    // Overflow: 65535 shows 5535 with dp lit on digit 3.
    bus.result = 16'd65535;
    wait_busy(1'b1, "ovf busy_up");
    wait_busy(1'b0, "ovf busy_dn");
    frame("ovf", 8'h92, 8'hB0, 8'h92, 8'h12, 8'h92, 8'hB0, 8'h92, 8'h12);

    // Hex mode.
    bus.hex_mode = 1'b1;
    bus.result   = 16'hBEEF;
    wait_busy(1'b1, "hex busy_up");
    wait_busy(1'b0, "hex busy_dn");
    frame("hex", 8'h8E, 8'h86, 8'h86, 8'h83, 8'h8E, 8'h86, 8'h86, 8'h83);

    // Change during conversion: 1 -> 2 at busy cycle 5.
    bus.hex_mode = 1'b0;
    bus.result   = 16'd1;
    tick(1);
    check("chg cyc1 busy", 16'(bus.busy), 16'h1);
    tick(4);
    bus.result = 16'd2;
    tick(12);
    check("chg cyc17 busy", 16'(bus.busy), 16'h1);
    tick(1);
    check("chg cyc18 busy", 16'(bus.busy), 16'h0);
    tick(1);
    check("chg cyc19 busy", 16'(bus.busy), 16'h1);
    tick(16);
    check("chg cyc35 busy", 16'(bus.busy), 16'h1);
    tick(1);
    check("chg cyc36 busy", 16'(bus.busy), 16'h0);
    frame("d2", 8'hA4, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hC0, 8'hC0, 8'hC0);

    // Display disable: pins dark, scan index keeps running.
    begin
      int w;
      w = 0;
      while (bus.AN !== 4'b0111 && w < 40) begin tick(1); w++; end
      w = 0;
      while (bus.AN === 4'b0111 && w < 10) begin tick(1); w++; end
    end
    bus.display = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check($sformatf("dis%0d an", i), 16'(bus.AN), 16'hF);
      check($sformatf("dis%0d bcd", i), 16'(bus.BCD), 16'hFF);
    end
    bus.display = 1'b1;
    tick(1);
    check("dis_on an", 16'(bus.AN), 16'hD);
    check("dis_on bcd", 16'(bus.BCD), 16'hFF);
    check("dis_on nb_bcd", 16'(bus_nb.BCD), 16'hC0);

    // Reset in the middle of a conversion.
    bus.result = 16'd1234;
    wait_busy(1'b1, "mr busy_up");
    tick(7);
    check("mr cyc8 busy", 16'(bus.busy), 16'h1);
    reset = 1'b0;
    #1;
    check_off("mr_async");
    tick(2);
    check_off("mr_hold");
    reset = 1'b1;
    tick(1);
    check("mr restart busy", 16'(bus.busy), 16'h1);
    wait_busy(1'b0, "mr busy_dn");
    frame("mr1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h99, 8'hB0, 8'hA4, 8'hF9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
